// File: rtl/batch_row_reader_pkg.sv
// Shared types for the batch-buffer readers: FSM states, default geometry and a row-beat record.
package coproc_pkg;

  localparam int DEFAULT_DATA_W = 64;
  localparam int DEFAULT_ROWS   = 8;
  localparam int DEFAULT_ROW_W  = $clog2(DEFAULT_ROWS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic [DEFAULT_DATA_W-1:0] data;
    logic [DEFAULT_ROW_W-1:0]  idx;
    logic                      last;
  } row_beat_t;

endpackage

// File: rtl/batch_row_reader.sv
// Reads one complete batch out of a row buffer, row 0..ROWS-1, and presents each
// row to the compute array over valid/ready; one batch per rising edge of i_rd_ready.
module batch_row_reader
  import coproc_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ROWS   = DEFAULT_ROWS,
  parameter int ROW_W  = $clog2(ROWS),
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic              i_en,
  output logic              o_rd_clk,
  output logic [ROW_W-1:0]  o_rd_row,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_rd_ready,
  output logic [DATA_W-1:0] o_row_data,
  output logic [ROW_W-1:0]  o_row_idx,
  output logic              o_row_valid,
  output logic              o_row_last,
  input  logic              i_row_ready,
  output logic              o_busy,
  output logic              o_done
);

  localparam int                LAT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LAT_W-1:0]  LAT_INIT = LAT_W'(RD_LAT - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(ROWS - 1);

  state_e              state_q, state_d;
  logic [ROW_W-1:0]    rd_row_q, rd_row_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0]   row_data_q, row_data_d;
  logic [ROW_W-1:0]    row_idx_q, row_idx_d;
  logic                row_valid_q, row_valid_d;
  logic                row_last_q, row_last_d;
  logic                done_q, done_d;
  logic                armed_q, armed_d;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      state_q     <= ST_IDLE;
      rd_row_q    <= '0;
      lat_cnt_q   <= '0;
      row_data_q  <= '0;
      row_idx_q   <= '0;
      row_valid_q <= 1'b0;
      row_last_q  <= 1'b0;
      done_q      <= 1'b0;
      armed_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      rd_row_q    <= rd_row_d;
      lat_cnt_q   <= lat_cnt_d;
      row_data_q  <= row_data_d;
      row_idx_q   <= row_idx_d;
      row_valid_q <= row_valid_d;
      row_last_q  <= row_last_d;
      done_q      <= done_d;
      armed_q     <= armed_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_row_d    = rd_row_q;
    lat_cnt_d   = lat_cnt_q;
    row_data_d  = row_data_q;
    row_idx_d   = row_idx_q;
    row_valid_d = row_valid_q;
    row_last_d  = row_last_q;
    done_d      = 1'b0;
    armed_d     = armed_q;

    case (state_q)
      ST_IDLE: begin
        if (i_en && i_rd_ready && armed_q) begin
          rd_row_d  = '0;
          lat_cnt_d = LAT_INIT;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_cnt_q != '0) begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end else begin
          row_data_d  = i_data;
          row_idx_d   = rd_row_q;
          row_valid_d = 1'b1;
          row_last_d  = (rd_row_q == ROW_MAX);
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (i_row_ready) begin
          row_valid_d = 1'b0;
          row_last_d  = 1'b0;
          if (row_idx_q == ROW_MAX) begin
            done_d   = 1'b1;
            armed_d  = 1'b0;
            rd_row_d = '0;
            state_d  = ST_IDLE;
          end else begin
            rd_row_d  = rd_row_q + ROW_W'(1);
            lat_cnt_d = LAT_INIT;
            state_d   = ST_WAIT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A low ready means the buffer has released the batch, so the next high is new data.
    if (!i_rd_ready) begin
      armed_d = 1'b1;
    end
  end

  assign o_rd_clk    = i_clk;
  assign o_rd_row    = rd_row_q;
  assign o_row_data  = row_data_q;
  assign o_row_idx   = row_idx_q;
  assign o_row_valid = row_valid_q;
  assign o_row_last  = row_last_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = done_q;

endmodule

// File: tb/tb_batch_row_reader.sv
// Directed bench: unit 0 runs with RD_LAT=1, unit 1 with RD_LAT=3, each fed by a small buffer model.
module tb_batch_row_reader;
  import coproc_pkg::*;

  localparam int DW = 64;
  localparam int NR = 8;
  localparam int RW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clr;
  logic          en[2];
  logic          rd_ready[2];
  logic          row_ready[2];
  logic [DW-1:0] data_in[2];
  logic          rd_clk[2];
  logic [RW-1:0] rd_row[2];
  logic [DW-1:0] row_data[2];
  logic [RW-1:0] row_idx[2];
  logic          row_valid[2];
  logic          row_last[2];
  logic          busy[2];
  logic          done[2];

  int n_total = 0;
  int n_bad   = 0;

  function automatic logic [DW-1:0] pat(input int r);
    logic [7:0] b;
    b = 8'h10 + 8'(r);
    return {8{b}};
  endfunction

  // Buffer models: unit 0 answers within the same cycle, unit 1 through two extra register stages.
  logic [DW-1:0] pipe1, pipe2;
  assign data_in[0] = pat(int'(rd_row[0]));
  always @(posedge clk) begin
    pipe1 <= pat(int'(rd_row[1]));
    pipe2 <= pipe1;
  end
  assign data_in[1] = pipe2;

  batch_row_reader #(.DATA_W(DW), .ROWS(NR), .ROW_W(RW), .RD_LAT(1)) u_lat1 (
    .i_clk(clk), .i_clr(clr), .i_en(en[0]), .o_rd_clk(rd_clk[0]), .o_rd_row(rd_row[0]),
    .i_data(data_in[0]), .i_rd_ready(rd_ready[0]), .o_row_data(row_data[0]),
    .o_row_idx(row_idx[0]), .o_row_valid(row_valid[0]), .o_row_last(row_last[0]),
    .i_row_ready(row_ready[0]), .o_busy(busy[0]), .o_done(done[0])
  );

  batch_row_reader #(.DATA_W(DW), .ROWS(NR), .ROW_W(RW), .RD_LAT(3)) u_lat3 (
    .i_clk(clk), .i_clr(clr), .i_en(en[1]), .o_rd_clk(rd_clk[1]), .o_rd_row(rd_row[1]),
    .i_data(data_in[1]), .i_rd_ready(rd_ready[1]), .o_row_data(row_data[1]),
    .o_row_idx(row_idx[1]), .o_row_valid(row_valid[1]), .o_row_last(row_last[1]),
    .i_row_ready(row_ready[1]), .o_busy(busy[1]), .o_done(done[1])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset(input int u);
    chk("rst_rd_row", 64'(rd_row[u]), 64'd0);
    chk("rst_row_data", row_data[u], 64'd0);
    chk("rst_row_idx", 64'(row_idx[u]), 64'd0);
    chk("rst_row_valid", 64'(row_valid[u]), 64'd0);
    chk("rst_row_last", 64'(row_last[u]), 64'd0);
    chk("rst_busy", 64'(busy[u]), 64'd0);
    chk("rst_done", 64'(done[u]), 64'd0);
  endtask

  // Called at a negedge; the start request is sampled on the following posedge.
  task automatic run_batch(input int u, input int lat, input int stall_row, input int abort_row);
    int        cnt;
    row_beat_t exp;
    en[u]        = 1'b1;
    rd_ready[u]  = 1'b1;
    row_ready[u] = 1'b1;
    for (int r = 0; r < NR; r++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
        if (r == 0 && cnt == 1) chk("busy_after_start", 64'(busy[u]), 64'd1);
      end while (!row_valid[u] && cnt < 40);
      chk("row_latency", 64'(cnt), 64'(1 + lat));
      exp.data = pat(r);
      exp.idx  = RW'(r);
      exp.last = (r == NR - 1);
      chk("row_data", row_data[u], exp.data);
      chk("row_idx", 64'(row_idx[u]), 64'(exp.idx));
      chk("row_last", 64'(row_last[u]), 64'(exp.last));
      $display("beat unit=%0d lat=%0d idx=%0d data=%h last=%0b", u, lat, row_idx[u], row_data[u], row_last[u]);
      if (r == abort_row) begin
        clr          = 1'b1;
        row_ready[u] = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        chk_reset(u);
        $display("abort unit=%0d at row %0d", u, r);
        return;
      end
      if (r == stall_row) begin
        row_ready[u] = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_valid", 64'(row_valid[u]), 64'd1);
          chk("stall_data", row_data[u], exp.data);
          chk("stall_idx", 64'(row_idx[u]), 64'(exp.idx));
          chk("stall_rd_row", 64'(rd_row[u]), 64'(exp.idx));
        end
        row_ready[u] = 1'b1;
      end
    end
    @(negedge clk);
    chk("done_pulse", 64'(done[u]), 64'd1);
    chk("valid_after_last", 64'(row_valid[u]), 64'd0);
    chk("busy_after_last", 64'(busy[u]), 64'd0);
    @(negedge clk);
    chk("done_clear", 64'(done[u]), 64'd0);
    $display("batch done unit=%0d", u);
  endtask

  initial begin
    clr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; rd_ready[i] = 1'b0; row_ready[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    clr = 1'b0;
    @(negedge clk);

    // Basic batch, RD_LAT=1
    run_batch(0, 1, -1, -1);

    // Ready held high: no second batch until it drops
    repeat (10) begin
      @(negedge clk);
      chk("no_rerun_busy", 64'(busy[0]), 64'd0);
    end
    rd_ready[0] = 1'b0;
    @(negedge clk);

    // Re-armed batch with backpressure on row 3
    run_batch(0, 1, 3, -1);

    // Abort in row 4, then a fresh batch with ready still high
    rd_ready[0] = 1'b0;
    @(negedge clk);
    run_batch(0, 1, -1, 4);
    chk("no_done_after_abort", 64'(done[0]), 64'd0);
    run_batch(0, 1, -1, -1);

    // Enable gating
    en[0]       = 1'b0;
    rd_ready[0] = 1'b0;
    @(negedge clk);
    rd_ready[0] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("en_gate_busy", 64'(busy[0]), 64'd0);
    end
    run_batch(0, 1, -1, -1);

    // RD_LAT=3 unit
    run_batch(1, 3, -1, -1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
